// File: rtl/int_source_ctrl_pkg.sv
// Shared definitions for the interrupt source block.
// The ESTAT.IS bit positions live here so the CSR unit and this block use the same mapping.
package int_source_ctrl_pkg;

  localparam int IS_HWI_LSB = 2;
  localparam int IS_HWI_MSB = 9;
  localparam int IS_HWI_W   = IS_HWI_MSB - IS_HWI_LSB + 1;

  typedef enum logic {
    LINE_LEVEL = 1'b0,
    LINE_EDGE  = 1'b1
  } line_mode_e;

endpackage

// File: rtl/int_line_filter.sv
// One interrupt line: synchroniser, stability filter and rising-edge detector.
// filt_o changes only after the synchronised pin has disagreed with it for FILT_CYCLES+1 cycles.
module int_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin_i,
  output logic filt_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_w;
  logic                   filt_q;
  logic                   filt_prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  if (FILT_CYCLES == 0) begin : g_nofilt

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        filt_q <= 1'b0;
      end else begin
        filt_q <= sync_w;
      end
    end

  end else begin : g_filt

    localparam int CW = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_d;

    // The counter resets on agreement and on acceptance, so it never passes CNT_MAX.
    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_w != filt_q) begin
        if (cnt_q == CNT_MAX) begin
          filt_d = sync_w;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_prev_q <= 1'b0;
    end else begin
      filt_prev_q <= filt_q;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = filt_q & ~filt_prev_q;

endmodule

// File: rtl/int_source_ctrl.sv
// Source side of the ESTAT.IS interrupt interface: filtered hardware lines latched as level
// or edge, the IPI bit, and a registered pending vector that can be frozen by hold.
module int_source_ctrl
  import int_source_ctrl_pkg::*;
#(
  parameter int NUM_HWI     = IS_HWI_W,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_HWI-1:0] intrpt,
  input  logic               mode_we,
  input  logic [NUM_HWI-1:0] mode_wdata,
  output logic [NUM_HWI-1:0] mode_rdata,
  input  logic               clr_we,
  input  logic [NUM_HWI-1:0] clr_mask,
  input  logic               ipi_set,
  input  logic               ipi_clr,
  input  logic               hold,
  output logic [NUM_HWI-1:0] hwi_pending,
  output logic               ipi_pending,
  output logic               any_pending
);

  logic [NUM_HWI-1:0] filt_w;
  logic [NUM_HWI-1:0] rise_w;

  logic [NUM_HWI-1:0] mode_q, mode_d;
  logic [NUM_HWI-1:0] pend_q, pend_d;
  logic               ipi_q, ipi_d;
  logic [NUM_HWI-1:0] hwi_out_q, hwi_out_d;
  logic               ipi_out_q, ipi_out_d;
  logic               any_out_q, any_out_d;

  for (genvar i = 0; i < NUM_HWI; i++) begin : g_line
    int_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_filter (
      .clk    (clk),
      .resetn (resetn),
      .pin_i  (intrpt[i]),
      .filt_o (filt_w[i]),
      .rise_o (rise_w[i])
    );
  end

  // Pending update uses the mode being written, so a line entering level mode follows
  // filt immediately and a line entering edge mode starts empty.
  always_comb begin
    mode_d = mode_q;
    pend_d = pend_q;
    if (mode_we) begin
      mode_d = mode_wdata;
    end
    for (int i = 0; i < NUM_HWI; i++) begin
      if (mode_d[i] == LINE_LEVEL) begin
        pend_d[i] = filt_w[i];
      end else if (mode_q[i] == LINE_LEVEL) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = rise_w[i] | (pend_q[i] & ~(clr_we & clr_mask[i]));
      end
    end
  end

  always_comb begin
    ipi_d     = ipi_set | (ipi_q & ~ipi_clr);
    hwi_out_d = hwi_out_q;
    ipi_out_d = ipi_out_q;
    any_out_d = any_out_q;
    if (!hold) begin
      hwi_out_d = pend_q;
      ipi_out_d = ipi_q;
      any_out_d = (|pend_q) | ipi_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q    <= '0;
      pend_q    <= '0;
      ipi_q     <= 1'b0;
      hwi_out_q <= '0;
      ipi_out_q <= 1'b0;
      any_out_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      ipi_q     <= ipi_d;
      hwi_out_q <= hwi_out_d;
      ipi_out_q <= ipi_out_d;
      any_out_q <= any_out_d;
    end
  end

  assign mode_rdata  = mode_q;
  assign hwi_pending = hwi_out_q;
  assign ipi_pending = ipi_out_q;
  assign any_pending = any_out_q;

endmodule
